// File: rtl/pipe_dmem_resp_if.sv
// Load/store request bus between the MEM stage (master) and the data-memory responder (slave).
interface pipe_dmem_resp_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        busy;
  logic        err;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack, busy, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack, busy, err
  );
endinterface

// File: rtl/pipe_dmem_resp.sv
// Data-memory responder with programmable wait states and a one-cycle ack.
// Optional misaligned-access flagging is enabled by defining DMEM_ALIGN_CHECK_EN.
module pipe_dmem_resp #(
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              clr,
  pipe_dmem_resp_if.slave   dmem
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    mis_q, mis_d;
  logic                    err_q, err_d;
  logic                    mis_in;
  logic                    capture, access, mem_we;
  logic [31:0]             mem [Depth];

`ifdef DMEM_ALIGN_CHECK_EN
  assign mis_in = |dmem.addr[1:0];
`else
  assign mis_in = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    mis_d   = mis_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    capture = 1'b0;
    access  = 1'b0;

    unique case (state_q)
      StIdle: capture = dmem.req;
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (dmem.req) capture = 1'b1;
        else          state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Requests are only ever taken from IDLE or RESP; WAIT ignores req entirely.
    if (capture) begin
      state_d = StWait;
      cnt_d   = 4'(WAIT_CYCLES);
      we_d    = dmem.we;
      idx_d   = dmem.addr[DEPTH_LOG2+1:2];
      wdata_d = dmem.wdata;
      mis_d   = mis_in;
    end

    if (access) begin
      err_d = mis_q;
      if (mis_q)      rdata_d = '0;
      else if (!we_q) rdata_d = mem[idx_q];
    end

    mem_we = access && we_q && !mis_q;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= wdata_q;
  end

  assign dmem.ack   = (state_q == StResp);
  assign dmem.busy  = (state_q != StIdle);
  assign dmem.err   = err_q;
  assign dmem.rdata = rdata_q;

endmodule

// File: tb/tb_pipe_dmem_resp.sv
// Directed bench for pipe_dmem_resp: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_pipe_dmem_resp;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pipe_dmem_resp_if b  ();
  pipe_dmem_resp_if b0 ();

  pipe_dmem_resp #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) u_dut (
    .clk  (clk),
    .clr  (clr),
    .dmem (b)
  );

  pipe_dmem_resp #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk  (clk),
    .clr  (clr),
    .dmem (b0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel) begin
      b0.req = r; b0.we = w; b0.addr = a; b0.wdata = d;
    end else begin
      b.req = r;  b.we = w;  b.addr = a;  b.wdata = d;
    end
  endtask

  function automatic logic ack_of(input bit sel);
    return sel ? b0.ack : b.ack;
  endfunction

  function automatic logic busy_of(input bit sel);
    return sel ? b0.busy : b.busy;
  endfunction

  // Single transaction; inputs are scrambled right after capture.
  task automatic xact(input bit sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                      output int lat, output int bcnt, output logic [31:0] rd,
                      output logic e, output logic ack_after);
    drive(sel, 1'b1, w, a, d);
    @(posedge clk); #1;
    drive(sel, 1'b0, ~w, ~a, ~d);
    lat  = 0;
    bcnt = 0;
    while (!ack_of(sel) && lat < 20) begin
      if (busy_of(sel)) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (busy_of(sel)) bcnt++;
    rd = sel ? b0.rdata : b.rdata;
    e  = sel ? b0.err : b.err;
    @(posedge clk); #1;
    ack_after = ack_of(sel);
  endtask

  int          lat, bcnt, k, acks;
  logic [31:0] rd;
  logic        e, aa;

  initial begin
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    #1 clr = 1'b1;
    #1;
    check("rst_ack",   {31'd0, b.ack},  32'd0);
    check("rst_busy",  {31'd0, b.busy}, 32'd0);
    check("rst_err",   {31'd0, b.err},  32'd0);
    check("rst_rdata", b.rdata,         32'd0);
    check("rst0_busy", {31'd0, b0.busy}, 32'd0);
    #10 clr = 1'b0;
    @(posedge clk); #1;

    // Store then timing of ack/busy with two wait states
    xact(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, lat, bcnt, rd, e, aa);
    check("st_lat",      lat, 32'd3);
    check("st_busy_cyc", bcnt, 32'd4);
    check("st_ack_fall", {31'd0, aa}, 32'd0);
    check("st_err",      {31'd0, e},  32'd0);
    check("st_rdata",    rd, 32'd0);

    xact(1'b0, 1'b0, 32'h0000_0010, 32'h0, lat, bcnt, rd, e, aa);
    check("ld10_data", rd, 32'hDEAD_BEEF);
    check("ld10_lat",  lat, 32'd3);
    xact(1'b0, 1'b0, 32'h0000_0410, 32'h0, lat, bcnt, rd, e, aa);
    check("ld410_alias", rd, 32'hDEAD_BEEF);
    check("rdata_hold",  b.rdata, 32'hDEAD_BEEF);

    // Back-to-back with req held high: store/load/store/load at 0x20
    drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h1111_1111);
    @(posedge clk); #1;
    for (int t = 0; t < 4; t++) begin
      k = 0;
      do begin
        @(posedge clk); #1;
        k++;
      end while (!b.ack && k < 12);
      check("b2b_gap", k, (t == 0) ? 32'd3 : 32'd4);
      if (t == 1) check("b2b_ld1", b.rdata, 32'h1111_1111);
      if (t == 3) check("b2b_ld2", b.rdata, 32'h2222_2222);
      case (t)
        0:       drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
        1:       drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h2222_2222);
        2:       drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
        default: drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      endcase
    end
    @(posedge clk); #1;
    check("b2b_idle_busy", {31'd0, b.busy}, 32'd0);

    // Reset aborts a store sitting in WAIT
    xact(1'b0, 1'b1, 32'h30, 32'hAAAA_AAAA, lat, bcnt, rd, e, aa);
    drive(1'b0, 1'b1, 1'b1, 32'h30, 32'h5555_5555);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    check("abort_in_wait", {31'd0, b.busy}, 32'd1);
    #2 clr = 1'b1;
    #1;
    check("clr_ack",   {31'd0, b.ack},  32'd0);
    check("clr_busy",  {31'd0, b.busy}, 32'd0);
    check("clr_err",   {31'd0, b.err},  32'd0);
    check("clr_rdata", b.rdata,         32'd0);
    #2 clr = 1'b0;
    acks = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (b.ack) acks++;
    end
    check("abort_no_ack", acks, 32'd0);
    xact(1'b0, 1'b0, 32'h30, 32'h0, lat, bcnt, rd, e, aa);
    check("abort_no_write", rd, 32'hAAAA_AAAA);

    // Zero wait states
    xact(1'b1, 1'b1, 32'h8, 32'h0000_00FF, lat, bcnt, rd, e, aa);
    check("w0_st_lat",   lat, 32'd1);
    check("w0_st_busy",  bcnt, 32'd2);
    check("w0_ack_fall", {31'd0, aa}, 32'd0);
    xact(1'b1, 1'b0, 32'h8, 32'h0, lat, bcnt, rd, e, aa);
    check("w0_ld_lat",  lat, 32'd1);
    check("w0_ld_data", rd, 32'h0000_00FF);
    drive(1'b1, 1'b1, 1'b0, 32'h8, 32'h0);
    @(posedge clk); #1;
    for (int t = 0; t < 3; t++) begin
      k = 0;
      do begin
        @(posedge clk); #1;
        k++;
      end while (!b0.ack && k < 12);
      check("w0_b2b_gap",  k, (t == 0) ? 32'd1 : 32'd2);
      check("w0_b2b_data", b0.rdata, 32'h0000_00FF);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;

    // Misaligned store to 0x13 (index 4)
    xact(1'b0, 1'b1, 32'h13, 32'h1234_5678, lat, bcnt, rd, e, aa);
    check("mis_lat", lat, 32'd3);
`ifdef DMEM_ALIGN_CHECK_EN
    check("mis_err",   {31'd0, e}, 32'd1);
    check("mis_rdata", rd, 32'd0);
    check("mis_err_fall", {31'd0, b.err}, 32'd0);
    xact(1'b0, 1'b0, 32'h10, 32'h0, lat, bcnt, rd, e, aa);
    check("mis_no_write", rd, 32'hDEAD_BEEF);
    check("al_err", {31'd0, e}, 32'd0);
`else
    check("mis_err",   {31'd0, e}, 32'd0);
    check("mis_rdata", rd, 32'hAAAA_AAAA);
    xact(1'b0, 1'b0, 32'h10, 32'h0, lat, bcnt, rd, e, aa);
    check("mis_written", rd, 32'h1234_5678);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
